instruction_fetch_unit: RTL and testbench

Instruction fetch (IF) stage of the MIPS pipeline and the initiator that reads the instruction memory. It owns the program counter, drives the word-aligned fetch address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register together with PC+4. It also handles stalls, flushes, branch and jump redirects, and out-of-range fetches from the execute/hazard logic.

---
 rtl/instruction_fetch_unit.sv | 87 ++++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, drives the combinational instruction
// memory and fills the IF/ID register, handling stalls, flushes, redirects and faults.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PC,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid,
    output logic [31:0] FetchCount,
    output logic        AddrFault
);

    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        pc_load;
    logic        bad_addr;

    assign IMemAddress = PC;

    always_comb begin
        pc_plus4 = PC + 32'd4;
        redirect = BranchTaken | JumpTaken;
        pc_load  = redirect | ~Stall;
        if (BranchTaken)    next_pc = BranchTarget;
        else if (JumpTaken) next_pc = JumpTarget;
        else if (Stall)     next_pc = PC;
        else                next_pc = pc_plus4;
        // A held PC was already checked when it was loaded (or is the trusted reset PC).
        bad_addr = pc_load && ((next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= IMEM_BYTES));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= RUN;
            PC             <= RESET_PC;
            ID_Instruction <= '0;
            ID_PCPlus4     <= '0;
            ID_Valid       <= 1'b0;
            FetchCount     <= '0;
            AddrFault      <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    PC <= next_pc;
                    if (bad_addr) begin
                        state     <= FAULT;
                        AddrFault <= 1'b1;
                    end
                    if (redirect || Flush) begin
                        ID_Instruction <= '0;
                        ID_PCPlus4     <= '0;
                        ID_Valid       <= 1'b0;
                    end else if (!Stall) begin
                        ID_Instruction <= IMemInstruction;
                        ID_PCPlus4     <= pc_plus4;
                        ID_Valid       <= 1'b1;
                        FetchCount     <= FetchCount + 32'd1;
                    end
                end
                FAULT: begin
                    ID_Instruction <= '0;
                    ID_PCPlus4     <= '0;
                    ID_Valid       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, corner sequences and
// randomized traffic checked against a rule-level reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr;
    logic        stall = 0, flush = 0, br = 0, jmp = 0;
    logic [31:0] btgt = '0, jtgt = '0;
    logic [31:0] pc, id_inst, id_pp4, fcount;
    logic        id_valid, fault;

    logic        rst2_n = 1'b0;
    logic [31:0] imem2_addr, imem2_instr;
    logic [31:0] pc2, id2_inst, id2_pp4, fcount2;
    logic        id2_valid, fault2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) * 32'd3;
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem2_instr = mem_word(imem2_addr);

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
        .Clk(clk), .Rst_n(rst_n), .IMemAddress(imem_addr), .IMemInstruction(imem_instr),
        .Stall(stall), .Flush(flush), .BranchTaken(br), .BranchTarget(btgt),
        .JumpTaken(jmp), .JumpTarget(jtgt), .PC(pc), .ID_Instruction(id_inst),
        .ID_PCPlus4(id_pp4), .ID_Valid(id_valid), .FetchCount(fcount), .AddrFault(fault)
    );

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
        .Clk(clk), .Rst_n(rst2_n), .IMemAddress(imem2_addr), .IMemInstruction(imem2_instr),
        .Stall(1'b0), .Flush(1'b0), .BranchTaken(1'b0), .BranchTarget(32'h0),
        .JumpTaken(1'b0), .JumpTarget(32'h0), .PC(pc2), .ID_Instruction(id2_inst),
        .ID_PCPlus4(id2_pp4), .ID_Valid(id2_valid), .FetchCount(fcount2), .AddrFault(fault2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_pp4, input logic e_v, input logic [31:0] e_cnt,
                           input logic e_f);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imem_addr"}, imem_addr, e_pc);
        chk({tag, ".id_inst"}, id_inst, e_inst);
        chk({tag, ".id_pcplus4"}, id_pp4, e_pp4);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(e_v));
        chk({tag, ".fetch_count"}, fcount, e_cnt);
        chk({tag, ".addr_fault"}, 32'(fault), 32'(e_f));
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        s, f, b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] e_pc, e_inst, e_pp4;
        logic        e_v;
        logic [31:0] e_cnt;
        logic        e_f;
    } vec_t;

    vec_t vecs[17];

    // Reference model state: updated from the fetch rules, one call per clock edge.
    logic [31:0] m_pc, m_inst, m_pp4, m_cnt;
    logic        m_v, m_f;

    task automatic model_reset();
        m_pc = 32'h0; m_inst = '0; m_pp4 = '0; m_v = 0; m_cnt = '0; m_f = 0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt);
        logic [31:0] tgt;
        logic        load;
        if (m_f) begin
            m_inst = '0; m_pp4 = '0; m_v = 0;
            return;
        end
        load = b || j || !s;
        tgt  = b ? bt : (j ? jt : m_pc + 32'd4);
        if (b || j || f) begin
            m_inst = '0; m_pp4 = '0; m_v = 0;
        end else if (!s) begin
            m_inst = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_v = 1; m_cnt = m_cnt + 1;
        end
        if (load) begin
            m_pc = tgt;
            if (tgt % 4 != 0 || tgt >= 32'd4096) m_f = 1;
        end
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,      0,0,      32'h4,  32'h0,  32'h4,  1,1,0};
        vecs[1]  = '{0,0,0,0,      0,0,      32'h8,  32'h3,  32'h8,  1,2,0};
        vecs[2]  = '{0,0,0,0,      0,0,      32'hC,  32'h6,  32'hC,  1,3,0};
        vecs[3]  = '{0,0,0,0,      0,0,      32'h10, 32'h9,  32'h10, 1,4,0};
        vecs[4]  = '{1,0,0,0,      0,0,      32'h10, 32'h9,  32'h10, 1,4,0};
        vecs[5]  = '{1,0,0,0,      0,0,      32'h10, 32'h9,  32'h10, 1,4,0};
        vecs[6]  = '{1,1,0,0,      0,0,      32'h10, 32'h0,  32'h0,  0,4,0};
        vecs[7]  = '{0,0,0,0,      0,0,      32'h14, 32'hC,  32'h14, 1,5,0};
        vecs[8]  = '{0,0,0,0,      1,32'h8,  32'h8,  32'h0,  32'h0,  0,5,0};
        vecs[9]  = '{0,0,1,32'h40, 0,0,      32'h40, 32'h0,  32'h0,  0,5,0};
        vecs[10] = '{0,0,0,0,      0,0,      32'h44, 32'h30, 32'h44, 1,6,0};
        vecs[11] = '{1,0,1,32'h80, 1,32'h20, 32'h80, 32'h0,  32'h0,  0,6,0};
        vecs[12] = '{1,0,0,0,      1,32'h100,32'h100,32'h0,  32'h0,  0,6,0};
        vecs[13] = '{0,0,0,0,      0,0,      32'h104,32'hC0, 32'h104,1,7,0};
        vecs[14] = '{0,0,0,0,      1,32'h42, 32'h42, 32'h0,  32'h0,  0,7,1};
        vecs[15] = '{0,0,0,0,      0,0,      32'h42, 32'h0,  32'h0,  0,7,1};
        vecs[16] = '{1,1,1,32'h40, 1,32'h8,  32'h42, 32'h0,  32'h0,  0,7,1};

        // Reset state, then first fetch address before any edge.
        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        #1;
        chk("cycle0.imem_addr", imem_addr, 32'h0);

        foreach (vecs[i]) begin
            stall = vecs[i].s; flush = vecs[i].f; br = vecs[i].b; btgt = vecs[i].bt;
            jmp = vecs[i].j; jtgt = vecs[i].jt;
            edge_sample();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pp4,
                    vecs[i].e_v, vecs[i].e_cnt, vecs[i].e_f);
            @(negedge clk);
        end
        stall = 0; flush = 0; br = 0; jmp = 0;

        // Small-memory instance has been fetching sequentially since release; check it separately.
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int unsigned k = 1; k <= 5; k++) begin
            edge_sample();
            if (k <= 3) begin
                chk($sformatf("small.pc%0d", k), pc2, 32'(k * 4));
                chk($sformatf("small.fault%0d", k), 32'(fault2), 32'h0);
            end else begin
                chk($sformatf("small.pc%0d", k), pc2, 32'h10);
                chk($sformatf("small.fault%0d", k), 32'(fault2), 32'h1);
                chk($sformatf("small.valid%0d", k), 32'(id2_valid), (k == 4) ? 32'h1 : 32'h0);
            end
        end

        // Async reset pulse mid-cycle while in FAULT with FetchCount=7.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("midreset", 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        #4 rst_n = 1'b1;
        edge_sample();
        chk_all("post_reset", 32'h4, 32'h0, 32'h4, 1, 32'h1, 0);

        // FetchCount wrap on a valid capture.
        @(negedge clk);
        force dut.FetchCount = 32'hFFFF_FFFF;
        #1 release dut.FetchCount;
        edge_sample();
        chk("wrap.fetch_count", fcount, 32'h0);
        chk("wrap.valid", 32'(id_valid), 32'h1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int unsigned c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 9) == 0);
            jmp   = ($urandom_range(0, 9) == 0);
            btgt  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            jtgt  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 39) == 0) btgt = btgt | 32'(($urandom_range(0, 1) == 0) ? 32'h2 : 32'h1000);
            model_step(stall, flush, br, btgt, jmp, jtgt);
            edge_sample();
            chk_all($sformatf("rand%0d", c), m_pc, m_inst, m_pp4, m_v, m_cnt, m_f);
            @(negedge clk);
            if (m_f && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
